// File: rtl/spi_target_regbank_if.sv
// SPI bus between the controller and one target: serial clock, chip select,
// frame direction, and the two data lines.
interface spi_target_regbank_if;
    logic seq_clk;
    logic cs;
    logic write;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output seq_clk, output cs, output write, output mosi,
                    input miso, input miso_oe);
    modport slave  (input seq_clk, input cs, input write, input mosi,
                    output miso, output miso_oe);
endinterface

// File: rtl/spi_target_regbank.sv
// SPI target that decodes 16-bit address+data frames into a local register bank.
// All SPI inputs are oversampled on clk; nothing is clocked by seq_clk.
module spi_target_regbank #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    spi_target_regbank_if.slave        spi,
    input  logic [7:0]                 rd_addr,
    output logic [7:0]                 rd_data,
    output logic                       reg_wr_en,
    output logic [7:0]                 reg_wr_addr,
    output logic [7:0]                 reg_wr_data,
    output logic                       busy,
    output logic                       frame_err
);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);
    // Synchroniser lanes are {seq_clk, cs, mosi, write}; cs resets to its idle-high level.
    localparam logic [3:0] SYNC_RST  = 4'b0100;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_d [SYNC_STAGES];
    logic       sclk_s, cs_s, mosi_s, wr_s;
    logic       sclk_dly_q, sclk_dly_d, cs_dly_q, cs_dly_d;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t     state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] addr_q, addr_d;
    logic       wr_frame_q, wr_frame_d;
    logic [7:0] tx_q, tx_d;
    logic       miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic       wr_en_q, wr_en_d, frame_err_q, frame_err_d;
    logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic       commit, completing;
    logic [7:0] rx_byte;

    logic [7:0] bank_q [DEPTH];
    logic [7:0] bank_d [DEPTH];

    function automatic logic addr_hit(input logic [7:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = {spi.seq_clk, spi.cs, spi.mosi, spi.write};
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
        for (gi = 0; gi < DEPTH; gi++) begin : g_bank
            assign bank_d[gi] = (commit && addr_q[IDX_W-1:0] == IDX_W'(gi)) ? rx_byte : bank_q[gi];
        end
    endgenerate

    assign {sclk_s, cs_s, mosi_s, wr_s} = sync_q[SYNC_STAGES-1];
    assign sclk_dly_d = sclk_s;
    assign cs_dly_d   = cs_s;
    assign sclk_rise  = sclk_s & ~sclk_dly_q;
    assign sclk_fall  = ~sclk_s & sclk_dly_q;
    assign cs_rise    = cs_s & ~cs_dly_q;
    assign cs_fall    = ~cs_s & cs_dly_q;
    assign rx_byte    = {shift_q[6:0], mosi_s};
    assign completing = (state_q == DATA) && sclk_rise && (bit_cnt_q == 5'd15);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        wr_frame_d  = wr_frame_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ADDR;
                    bit_cnt_d = '0;
                end
            end
            ADDR: begin
                if (sclk_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        addr_d     = rx_byte;
                        wr_frame_d = wr_s;
                        state_d    = DATA;
                        if (!wr_s) begin
                            tx_d      = addr_hit(rx_byte) ? bank_q[rx_byte[IDX_W-1:0]] : 8'h00;
                            miso_oe_d = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (sclk_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd15) begin
                        state_d   = DONE;
                        miso_oe_d = 1'b0;
                        miso_d    = 1'b0;
                        if (wr_frame_q && addr_hit(addr_q)) begin
                            commit    = 1'b1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = rx_byte;
                        end
                    end
                end else if (sclk_fall && !wr_frame_q) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
            end
            default: ;
        endcase
        // A cs rise in the same sample as the final rise lets the frame finish cleanly.
        if (state_q != IDLE && cs_rise) begin
            state_d   = IDLE;
            miso_oe_d = 1'b0;
            miso_d    = 1'b0;
            if (state_q != DONE && !completing) frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= 8'h00;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            wr_frame_q  <= 1'b0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            bank_q      <= bank_d;
            sclk_dly_q  <= sclk_dly_d;
            cs_dly_q    <= cs_dly_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            wr_frame_q  <= wr_frame_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rd_data     = addr_hit(rd_addr) ? bank_q[rd_addr[IDX_W-1:0]] : 8'h00;
    assign spi.miso    = miso_q;
    assign spi.miso_oe = miso_oe_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign busy        = (state_q != IDLE);
    assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_spi_target_regbank.sv
// Directed bench for spi_target_regbank: drives SPI frames and checks the DUT
// every cycle against a frame-level model of the register bank.
module tb_spi_target_regbank;
    localparam int DEPTH = 16;
    localparam int HP    = 8;   // seq_clk half period in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rd_addr, rd_data, reg_wr_addr, reg_wr_data;
    logic       reg_wr_en, busy, frame_err;

    spi_target_regbank_if bus();

    spi_target_regbank #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi        (bus),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  model_bank [DEPTH];
    logic [15:0] exp_wr_q [$];
    logic [15:0] exp_wr;
    int          ferr_seen = 0;
    bit          settled = 1'b0;
    logic [7:0]  miso_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        return (a < DEPTH) ? model_bank[a[3:0]] : 8'h00;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset) begin
            if (reg_wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    check("reg_wr_en_unexpected", reg_wr_en, 0);
                end else begin
                    exp_wr = exp_wr_q.pop_front();
                    check("reg_wr_addr", reg_wr_addr, exp_wr[15:8]);
                    check("reg_wr_data", reg_wr_data, exp_wr[7:0]);
                end
            end
            if (frame_err) ferr_seen++;
            if (settled) begin
                check("rd_data", rd_data, model_rd(rd_addr));
                check("idle_busy", busy, 0);
                check("idle_miso_oe", bus.miso_oe, 0);
                check("idle_miso", bus.miso, 0);
            end
        end
    end

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) model_bank[i] = 8'h00;
        exp_wr_q.delete();
    endtask

    // nrises: seq_clk rises before cs is released; rst_at: rise index after
    // which reset is asserted (-1 none); sim_cs: release cs with the 16th rise.
    task automatic spi_frame(input logic [7:0] a, input logic [7:0] d, input logic wr,
                             input int nrises, input int rst_at, input bit sim_cs);
        logic [15:0] f;
        logic [7:0]  exp_rd;
        int          fe0;
        f      = {a, d};
        exp_rd = model_rd(a);
        fe0    = ferr_seen;
        settled = 1'b0;
        if (wr && nrises == 16 && rst_at < 0 && a < DEPTH) exp_wr_q.push_back(f);
        bus.write = wr;
        bus.mosi  = f[15];
        bus.cs    = 1'b0;
        clks(HP);
        miso_byte = 8'h00;
        for (int i = 0; i < nrises; i++) begin
            bus.seq_clk = 1'b1;
            if (sim_cs && i == 15) bus.cs = 1'b1;
            check("busy_in_frame", busy, 1);
            if (i >= 8) begin
                check("miso_oe_data", bus.miso_oe, {31'd0, !wr});
                miso_byte = {miso_byte[6:0], bus.miso};
                check("miso_bit", bus.miso, wr ? 1'b0 : exp_rd[15-i]);
            end else begin
                check("miso_oe_addr", bus.miso_oe, 0);
            end
            clks(HP);
            if (rst_at == i) begin
                reset = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_frame_err", frame_err, 0);
                check("rst_reg_wr_en", reg_wr_en, 0);
                check("rst_reg_wr_addr", reg_wr_addr, 0);
                check("rst_reg_wr_data", reg_wr_data, 0);
                check("rst_miso", bus.miso, 0);
                check("rst_miso_oe", bus.miso_oe, 0);
                check("rst_rd_data", rd_data, 0);
                bus.cs = 1'b1;
                bus.seq_clk = 1'b0;
                clks(5);
                reset = 1'b1;
                reset_model();
                clks(10);
                check("rst_no_frame_err", ferr_seen - fe0, 0);
                settled = 1'b1;
                return;
            end
            bus.seq_clk = 1'b0;
            if (i < 15) bus.mosi = f[14-i];
            clks(HP);
        end
        bus.cs = 1'b1;
        clks(10);
        check("frame_err_count", ferr_seen - fe0, (nrises < 16) ? 1 : 0);
        check("wr_pulses_seen", exp_wr_q.size(), 0);
        if (wr && nrises == 16 && a < DEPTH) model_bank[a[3:0]] = d;
        settled = 1'b1;
    endtask

    task automatic sweep();
        logic [7:0] addrs [8];
        addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h0F, 8'h10, 8'h20};
        for (int i = 0; i < 8; i++) begin
            rd_addr = addrs[i];
            clks(2);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset = 1'b0;
        bus.cs = 1'b1;
        bus.seq_clk = 1'b0;
        bus.mosi = 1'b0;
        bus.write = 1'b0;
        rd_addr = 8'h00;
        reset_model();
        clks(3);
        check("reset_busy", busy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_reg_wr_en", reg_wr_en, 0);
        check("reset_reg_wr_addr", reg_wr_addr, 0);
        check("reset_reg_wr_data", reg_wr_data, 0);
        check("reset_miso", bus.miso, 0);
        check("reset_miso_oe", bus.miso_oe, 0);
        check("reset_rd_data", rd_data, 0);
        reset = 1'b1;
        settled = 1'b1;
        clks(5);

        // 1: write 0x03 <- 0xA5
        spi_frame(8'h03, 8'hA5, 1'b1, 16, -1, 1'b0);
        rd_addr = 8'h03;
        clks(1);
        check("t1_rd_data", rd_data, 8'hA5);
        check("t1_wr_addr", reg_wr_addr, 8'h03);
        check("t1_wr_data", reg_wr_data, 8'hA5);
        sweep();

        // 2: read 0x03
        spi_frame(8'h03, 8'h00, 1'b0, 16, -1, 1'b0);
        check("t2_miso_byte", miso_byte, 8'hA5);

        // 3: short write frame to 0x07
        spi_frame(8'h07, 8'h3C, 1'b1, 10, -1, 1'b0);
        rd_addr = 8'h07;
        clks(1);
        check("t3_rd_data", rd_data, 8'h00);
        check("t3_busy", busy, 0);

        // 4: out-of-range write and read
        spi_frame(8'h20, 8'hFF, 1'b1, 16, -1, 1'b0);
        sweep();
        spi_frame(8'h20, 8'h00, 1'b0, 16, -1, 1'b0);
        check("t4_miso_byte", miso_byte, 8'h00);

        // 5: reset during bit 12 of a write, then a full frame
        rd_addr = 8'h03;
        spi_frame(8'h05, 8'h77, 1'b1, 16, 11, 1'b0);
        clks(1);
        check("t5_bank_cleared", rd_data, 8'h00);
        spi_frame(8'h05, 8'h77, 1'b1, 16, -1, 1'b0);
        rd_addr = 8'h05;
        clks(1);
        check("t5_rd_data", rd_data, 8'h77);

        // cs release coincident with the 16th rise still commits
        spi_frame(8'h02, 8'h5A, 1'b1, 16, -1, 1'b1);
        rd_addr = 8'h02;
        clks(1);
        check("sim_cs_rd_data", rd_data, 8'h5A);

        // 6: back-to-back write/read with two idle seq_clk periods
        spi_frame(8'h01, 8'h11, 1'b1, 16, -1, 1'b0);
        clks(4 * HP);
        spi_frame(8'h01, 8'h00, 1'b0, 16, -1, 1'b0);
        check("t6_miso_byte", miso_byte, 8'h11);
        bus.write = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.mosi = 1'($urandom_range(0, 1));
            bus.seq_clk = 1'b1;
            clks(HP);
            bus.seq_clk = 1'b0;
            clks(HP);
        end
        check("t6_no_frame_err", frame_err, 0);
        sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
